// File: rtl/fuel_pkg.sv
// rtl/fuel_pkg.sv - shared types, widths and saturation helper for the fuel-tank model
// Purpose: state enum, gas word width and the 33-bit to GAS_W clamp used by fuel_tank.
// Ports: none (package).
package fuel_pkg;

   localparam int GAS_W = 32;

   typedef enum logic [1:0] {
      OFF    = 2'd0,
      RUN    = 2'd1,
      REFUEL = 2'd2
   } fuel_state_t;

   // Saturate a widened signed result into [0, cap] at GAS_W bits.
   function automatic logic signed [GAS_W-1:0] clamp_gas(input logic signed [GAS_W:0] v,
                                                          input int cap);
      logic signed [GAS_W:0] cap_x;
      cap_x = (GAS_W+1)'(cap);
      if (v < 0)
         return '0;
      else if (v > cap_x)
         return cap_x[GAS_W-1:0];
      else
         return v[GAS_W-1:0];
   endfunction

endpackage

// File: rtl/fuel_tank_if.sv
// rtl/fuel_tank_if.sv - ignition/odometer/refuel inputs and level outputs of fuel_tank
// Purpose: bundles the fuel-tank signals; master drives the inputs, slave is the tank.
// Signals: engine_on, dist_pulse, refuel_req (to tank); gas, refuel_busy,
//          refuel_done, empty (from tank).
interface fuel_tank_if;

   logic                                engine_on;
   logic                                dist_pulse;
   logic                                refuel_req;
   logic signed [fuel_pkg::GAS_W-1:0]   gas;
   logic                                refuel_busy;
   logic                                refuel_done;
   logic                                empty;

   modport master (
      output engine_on, dist_pulse, refuel_req,
      input  gas, refuel_busy, refuel_done, empty
   );

   modport slave (
      input  engine_on, dist_pulse, refuel_req,
      output gas, refuel_busy, refuel_done, empty
   );

endinterface

// File: rtl/fuel_tank_dist_divider.sv
// rtl/fuel_tank_dist_divider.sv - modulo-DIV event counter with one-cycle step strobe
// Purpose: counts enabled cycles 0..DIV-1; step is high on the enabled cycle that wraps.
// Ports: clock, reset (async active-low), enable (count this cycle), clear (force to 0,
//        wins over enable), step (wrap strobe, combinational).
module dist_divider #(
   parameter int DIV = 8
) (
   input  logic clock,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic step
);

   localparam int            W    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0]  LAST = W'(DIV - 1);

   logic [W-1:0] cnt_q, cnt_d;
   logic         at_last;

   assign at_last = (cnt_q == LAST);
   assign step    = enable & ~clear & at_last;

   always_comb begin
      cnt_d = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (enable)
         cnt_d = at_last ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/fuel_tank.sv
// rtl/fuel_tank.sv - fuel-level model: distance burn, refuel FSM, signed level output
// Purpose: converts odometer pulses into fuel burn, services refuel requests and
//          presents the clamped level as a signed 32-bit gas word.
// Ports: clock, reset (async active-low), bus (fuel_tank_if.slave: engine_on,
//        dist_pulse, refuel_req in; gas, refuel_busy, refuel_done, empty out).
// Option: FUEL_TANK_IDLE_BURN_EN adds an idle-time burn every IDLE_PERIOD RUN cycles
//         without a dist_pulse.
module fuel_tank
   import fuel_pkg::*;
#(
   parameter int CAPACITY      = 100,
   parameter int INIT_GAS      = 100,
   parameter int DIST_PER_UNIT = 8,
   parameter int BURN          = 1,
   parameter int REFUEL_RATE   = 2,
   parameter int IDLE_PERIOD   = 64
) (
   input  logic        clock,
   input  logic        reset,
   fuel_tank_if.slave  bus
);

   localparam logic signed [GAS_W-1:0] CAP_W = GAS_W'(CAPACITY);

   fuel_state_t              state_q, state_d;
   logic signed [GAS_W-1:0]  gas_q, gas_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;
   logic                     empty_q, empty_d;

   logic                     in_run;
   logic                     dist_step;
   logic                     idle_step;
   logic                     burn;
   logic signed [GAS_W:0]    gas_x;
   logic signed [GAS_W-1:0]  burn_gas;
   logic signed [GAS_W-1:0]  fill_gas;

   assign in_run = (state_q == RUN);

   dist_divider #(.DIV(DIST_PER_UNIT)) u_dist (
      .clock  (clock),
      .reset  (reset),
      .enable (in_run & bus.dist_pulse),
      .clear  (1'b0),
      .step   (dist_step)
   );

`ifdef FUEL_TANK_IDLE_BURN_EN
   // Idle counter advances on pulse-free RUN cycles; any RUN pulse restarts it.
   dist_divider #(.DIV(IDLE_PERIOD)) u_idle (
      .clock  (clock),
      .reset  (reset),
      .enable (in_run & ~bus.dist_pulse),
      .clear  (in_run & bus.dist_pulse),
      .step   (idle_step)
   );
`else
   logic [31:0] unused_idle_period;
   assign unused_idle_period = IDLE_PERIOD;
   assign idle_step          = 1'b0;
`endif

   // Coincident idle and distance steps burn only once.
   assign burn     = dist_step | idle_step;
   assign gas_x    = {gas_q[GAS_W-1], gas_q};
   assign burn_gas = clamp_gas(gas_x - (GAS_W+1)'(BURN), CAPACITY);
   assign fill_gas = clamp_gas(gas_x + (GAS_W+1)'(REFUEL_RATE), CAPACITY);

   always_comb begin
      state_d = state_q;
      gas_d   = gas_q;
      done_d  = 1'b0;
      case (state_q)
         OFF: begin
            if (bus.engine_on)
               state_d = RUN;
            else if (bus.refuel_req && (gas_q < CAP_W))
               state_d = REFUEL;
         end
         RUN: begin
            if (burn)
               gas_d = burn_gas;
            if (!bus.engine_on)
               state_d = OFF;
         end
         REFUEL: begin
            // Ignition or a dropped request exits before this cycle's add.
            if (bus.engine_on)
               state_d = RUN;
            else if (!bus.refuel_req)
               state_d = OFF;
            else begin
               gas_d = fill_gas;
               if (fill_gas == CAP_W) begin
                  done_d  = 1'b1;
                  state_d = OFF;
               end
            end
         end
         default: state_d = OFF;
      endcase
      busy_d  = (state_d == REFUEL);
      empty_d = (gas_d == '0);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= OFF;
         gas_q   <= GAS_W'(INIT_GAS);
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         empty_q <= (INIT_GAS == 0);
      end else begin
         state_q <= state_d;
         gas_q   <= gas_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         empty_q <= empty_d;
      end
   end

   assign bus.gas         = gas_q;
   assign bus.refuel_busy = busy_q;
   assign bus.refuel_done = done_q;
   assign bus.empty       = empty_q;

endmodule

// File: tb/tb_fuel_tank.sv
// tb/tb_fuel_tank.sv - self-checking bench for fuel_tank with a behavioural level model
module tb_fuel_tank;

   localparam int CAP  = 100;
   localparam int INIT = 100;
   localparam int DPU  = 8;
   localparam int BRN  = 1;
   localparam int RATE = 2;
   localparam int IP   = 64;

   logic clock = 1'b0;
   logic rst_n = 1'b1;
   always #5 clock = ~clock;

   fuel_tank_if bus ();

   fuel_tank #(
      .CAPACITY      (CAP),
      .INIT_GAS      (INIT),
      .DIST_PER_UNIT (DPU),
      .BURN          (BRN),
      .REFUEL_RATE   (RATE),
      .IDLE_PERIOD   (IP)
   ) dut (
      .clock (clock),
      .reset (rst_n),
      .bus   (bus)
   );

   int n_vec  = 0;
   int n_miss = 0;
   bit cmp_en = 1'b0;

   task automatic check(input string name, input logic signed [63:0] act,
                        input logic signed [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Level model: mode 0 = engine off, 1 = driving, 2 = filling.
   int m_mode  = 0;
   int m_gas   = INIT;
   int m_pulse = 0;
   int m_idle  = 0;
   bit m_done  = 1'b0;

   always @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         m_mode = 0; m_gas = INIT; m_pulse = 0; m_idle = 0; m_done = 1'b0;
      end else begin
         bit do_burn;
         do_burn = 1'b0;
         m_done  = 1'b0;
         if (m_mode == 1) begin
            if (bus.dist_pulse) begin
               m_pulse = m_pulse + 1;
               if (m_pulse == DPU) begin m_pulse = 0; do_burn = 1'b1; end
            end
`ifdef FUEL_TANK_IDLE_BURN_EN
            if (bus.dist_pulse) m_idle = 0;
            else begin
               m_idle = m_idle + 1;
               if (m_idle == IP) begin m_idle = 0; do_burn = 1'b1; end
            end
`endif
            if (do_burn) m_gas = (m_gas - BRN < 0) ? 0 : m_gas - BRN;
            if (!bus.engine_on) m_mode = 0;
         end else if (m_mode == 2) begin
            if (bus.engine_on) m_mode = 1;
            else if (!bus.refuel_req) m_mode = 0;
            else begin
               m_gas = (m_gas + RATE > CAP) ? CAP : m_gas + RATE;
               if (m_gas == CAP) begin m_done = 1'b1; m_mode = 0; end
            end
         end else begin
            if (bus.engine_on) m_mode = 1;
            else if (bus.refuel_req && m_gas < CAP) m_mode = 2;
         end
      end
   end

   always @(negedge clock) begin
      if (cmp_en && rst_n) begin
         check("gas", bus.gas, m_gas);
         check("empty", bus.empty, (m_gas == 0));
         check("refuel_busy", bus.refuel_busy, (m_mode == 2));
         check("refuel_done", bus.refuel_done, m_done);
      end
   end

   task automatic tick(input logic e, input logic p, input logic r);
      bus.engine_on  = e;
      bus.dist_pulse = p;
      bus.refuel_req = r;
      @(posedge clock);
      #1;
   endtask

   task automatic pulses(input int n);
      for (int i = 0; i < n; i++) tick(1'b1, 1'b1, 1'b0);
   endtask

   initial begin
      bus.engine_on  = 1'b0;
      bus.dist_pulse = 1'b0;
      bus.refuel_req = 1'b0;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clock);
      #1 rst_n = 1'b1;
      check("rst_gas", bus.gas, 100);
      check("rst_empty", bus.empty, 0);
      check("rst_busy", bus.refuel_busy, 0);
      check("rst_done", bus.refuel_done, 0);
      cmp_en = 1'b1;

      // Eight back-to-back pulses burn one unit.
      tick(1'b1, 1'b0, 1'b0);
      pulses(7);
      check("t1_before8", bus.gas, 100);
      pulses(1);
      check("t1_after8", bus.gas, 99);
      pulses(8);
      check("t1_wrap", bus.gas, 98);

      // Pulses with engine off are ignored.
      tick(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 1'b0);
      check("off_pulses", bus.gas, 98);

      // Ignition beats refuel request; refuel ignored while running.
      tick(1'b1, 1'b0, 1'b1);
      check("eng_wins_busy", bus.refuel_busy, 0);
      for (int i = 0; i < 24; i++) tick(1'b1, 1'b1, 1'b1);
      check("run_to_95", bus.gas, 95);
      check("run_req_busy", bus.refuel_busy, 0);

      // Full refuel from 95.
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b1);
      check("rf_entry_busy", bus.refuel_busy, 1);
      check("rf_entry_gas", bus.gas, 95);
      tick(1'b0, 1'b0, 1'b1);
      check("rf_97", bus.gas, 97);
      tick(1'b0, 1'b0, 1'b1);
      check("rf_99", bus.gas, 99);
      tick(1'b0, 1'b0, 1'b1);
      check("rf_100", bus.gas, 100);
      check("rf_done", bus.refuel_done, 1);
      check("rf_busy_off", bus.refuel_busy, 0);
      tick(1'b0, 1'b0, 1'b1);
      check("rf_done_once", bus.refuel_done, 0);
      check("rf_full_noentry", bus.refuel_busy, 0);

      // Burn to 50, refuel three adds, ignition exits.
      tick(1'b1, 1'b0, 1'b0);
      pulses(400);
      check("burn_to_50", bus.gas, 50);
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b1);
      repeat (3) tick(1'b0, 1'b0, 1'b1);
      check("rf3_gas", bus.gas, 56);
      tick(1'b1, 1'b0, 1'b1);
      check("ign_exit_gas", bus.gas, 56);
      check("ign_exit_done", bus.refuel_done, 0);
      check("ign_exit_busy", bus.refuel_busy, 0);

      // Dropped request keeps the partial fill.
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b1);
      repeat (2) tick(1'b0, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 1'b0);
      check("abort_gas", bus.gas, 60);
      check("abort_busy", bus.refuel_busy, 0);

      // Burn to empty and beyond.
      tick(1'b1, 1'b0, 1'b0);
      pulses(480);
      check("empty_gas", bus.gas, 0);
      check("empty_flag", bus.empty, 1);
      pulses(16);
      check("empty_sat", bus.gas, 0);
      check("empty_still", bus.empty, 1);

      // Asynchronous reset in the middle of a refuel.
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b1);
      tick(1'b0, 1'b0, 1'b1);
      check("pre_rst_gas", bus.gas, 2);
      check("pre_rst_busy", bus.refuel_busy, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_gas", bus.gas, 100);
      check("async_busy", bus.refuel_busy, 0);
      check("async_done", bus.refuel_done, 0);
      check("async_empty", bus.empty, 0);
      @(posedge clock);
      #1 rst_n = 1'b1;
      repeat (3) tick(1'b0, 1'b0, 1'b1);
      check("post_rst_done", bus.refuel_done, 0);
      check("post_rst_gas", bus.gas, 100);

      // Idle RUN without pulses: burns only with the idle feature.
      tick(1'b1, 1'b0, 1'b0);
      repeat (128) tick(1'b1, 1'b0, 1'b0);
`ifdef FUEL_TANK_IDLE_BURN_EN
      check("idle_128", bus.gas, 98);
`else
      check("idle_128", bus.gas, 100);
`endif
      repeat (60) tick(1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 1'b0);
      repeat (40) tick(1'b1, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);

      cmp_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/fuel_tank.md
# fuel_tank

Fuel-level model feeding the low-fuel warning stage. Converts per-distance odometer pulses into fuel consumption, services refuel requests through a small state machine, and presents the current level as a signed 32-bit `gas` word that the warning block thresholds directly. Sits between the odometer/ignition inputs and the warning logic in the vehicle-monitor datapath.

## Interface
- `CAPACITY`, 100: full-tank level; `gas` never exceeds it.
- `INIT_GAS`, 100: level loaded on reset; must satisfy 0..CAPACITY.
- `DIST_PER_UNIT`, 8: odometer pulses per fuel-consumption step; must be ≥1.
- `BURN`, 1: units subtracted per consumption step.
- `REFUEL_RATE`, 2: units added per cycle while refuelling.
- `IDLE_PERIOD`, 64: cycles per idle-burn step; used only with the idle-burn feature.

- `clock`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-low reset.
- `engine_on`  in  1  ignition level.
- `dist_pulse`  in  1  single-cycle odometer tick.
- `refuel_req`  in  1  level request to refuel.
- `gas`  out  32 signed  current fuel level, registered.
- `refuel_busy`  out  1  high while in REFUEL.
- `refuel_done`  out  1  one-cycle pulse when the tank reaches CAPACITY during REFUEL.
- `empty`  out  1  registered; high when `gas` == 0.

## Operation
- States: OFF (engine off, idle), RUN (engine on), REFUEL.
- OFF→RUN when `engine_on`=1. Otherwise OFF→REFUEL when `refuel_req`=1 and `gas` < CAPACITY. `engine_on` wins when both are high.
- RUN→OFF when `engine_on`=0. `refuel_req` is ignored in RUN.
- REFUEL→OFF when `refuel_req` drops, or when the tank fills (this cycle's add reaches CAPACITY).
- REFUEL→RUN when `engine_on` rises; no `refuel_done` on this exit.
- Distance counter `dist_cnt`:
  - Range 0..DIST_PER_UNIT-1; counts `dist_pulse` only in RUN.
  - On a pulse at DIST_PER_UNIT-1 it wraps to 0 and `gas` -= BURN, saturating at 0 (never negative).
  - Retains its value in OFF/REFUEL.
- REFUEL: `gas` += REFUEL_RATE each cycle, saturating at CAPACITY.
  - Pulse `refuel_done` on the cycle `gas` becomes CAPACITY.
  - Partial fuel added before an abort is kept.
- Arithmetic: 33-bit signed intermediate, then clamp to [0, CAPACITY].
- `dist_pulse` outside RUN: ignored, no count.

## Timing
- Reset (asserted asynchronously):
  - `gas`=INIT_GAS, state OFF, `dist_cnt`=0, idle counter 0.
  - `refuel_busy`=0, `refuel_done`=0, `empty`=(INIT_GAS==0).
- `gas` updates on the clock edge that samples the qualifying `dist_pulse`; visible one cycle after the pulse is presented.
- `empty` and `refuel_busy` are registered and track `gas`/state on the same edge (no extra lag).
- REFUEL entry takes 1 cycle from `refuel_req` sampled high; the first add happens on the edge after entry.
- Reset released mid-REFUEL: the block restarts in OFF with INIT_GAS, and `refuel_done` stays 0.
- Back-to-back pulses each count; every pulse is processed, with no drops.

## Configuration
- `FUEL_TANK_IDLE_BURN_EN` defined:
  - In RUN, an idle counter increments each cycle with no `dist_pulse`.
  - On reaching IDLE_PERIOD-1 it wraps and `gas` -= BURN (saturating).
  - A `dist_pulse` clears the idle counter.
  - If an idle burn and a distance burn fall on the same cycle, only one BURN is applied.
- Undefined: no idle counter; fuel is consumed by distance only.

## Structure
- Shared package `fuel_pkg`:
  - state enum `fuel_state_t` {OFF, RUN, REFUEL};
  - `GAS_W`=32;
  - clamp helper function for the 33-bit to GAS_W saturation.
- Sub-module `dist_divider`: modulo-DIST_PER_UNIT pulse counter with `enable`, outputting a one-cycle `step` strobe. It is reused for the idle counter when the feature is enabled.

## Test plan
- Reset with defaults, release, `engine_on`=1, 8 `dist_pulse` → `gas` 100→99 one cycle after the 8th pulse; `dist_cnt` back to 0.
- `gas`=1 (`INIT_GAS`=1), 16 pulses in RUN → `gas`=0 after the 8th pulse and stays 0; `empty`=1; no negative value.
- `engine_on`=0, `gas`=95, hold `refuel_req` → `refuel_busy`=1, `gas` 97, 99, 100; `refuel_done` pulses once on 100; state returns to OFF.
- REFUEL from 50, raise `engine_on` after 3 adds → `gas`=56, state RUN, `refuel_done`=0.
- Assert `reset` low mid-REFUEL → all outputs at reset values immediately (asynchronous), without waiting for a clock edge.
- With `FUEL_TANK_IDLE_BURN_EN`: RUN with no pulses for 128 cycles → `gas` 100→98; a `dist_pulse` at cycle 60 restarts the idle count.
